// File: rtl/score_disp_ctrl_pkg.sv
// score_disp_pkg: shared states, BCD nibble width and the power-of-ten helper for the score display.
package score_disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int BCD_W = 4;
  function automatic logic [63:0] pow10(input int n);
    pow10 = 64'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 64'd10;
  endfunction
endpackage

// File: rtl/score_disp_ctrl_if.sv
// score_disp_ctrl_if: load/busy conversion handshake and BCD result between score logic and display.
interface score_disp_ctrl_if import score_disp_pkg::*; #(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
);
  logic [WIDTH-1:0]        value_i;
  logic                    load_i;
  logic                    busy_o;
  logic                    done_o;
  logic                    ovf_o;
  logic [BCD_W*DIGITS-1:0] digits_o;
  modport master (output value_i, load_i, input busy_o, done_o, ovf_o, digits_o);
  modport slave  (input value_i, load_i, output busy_o, done_o, ovf_o, digits_o);
endinterface

// File: rtl/score_disp_ctrl_bcd_add3.sv
// bcd_add3: one double-dabble correction step, nibbles of 5 or more get +3 before the shift.
module bcd_add3 import score_disp_pkg::*; (
  input  logic [BCD_W-1:0] nib_i,
  output logic [BCD_W-1:0] nib_o
);
  assign nib_o = nib_i >= BCD_W'(5) ? nib_i + BCD_W'(3) : nib_i;
endmodule

// File: rtl/score_disp_ctrl.sv
// score_disp_ctrl: sequential binary-to-BCD converter plus free-running multiplexed 7-seg digit scan.
// Define SCORE_DISP_LZB_EN to blank leading zero digits (digit 0 is always shown).
module score_disp_ctrl import score_disp_pkg::*; #(
  parameter int WIDTH       = 12,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_disp_ctrl_if.slave     bus,
  output logic [DIGITS-1:0]    an_o,
  output logic [BCD_W-1:0]     digit_o
);
  localparam int SW = BCD_W * (DIGITS + 1);
  localparam int DW = BCD_W * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]     scr_q, scr_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic              big_q, big_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic              ovf_q, ovf_d;
  logic [RW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]        adj;
  logic [SW+WIDTH-1:0]  sh;
  logic                 sat;
  for (genvar g = 0; g <= DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (.nib_i(scr_q[BCD_W*g +: BCD_W]), .nib_o(adj[BCD_W*g +: BCD_W]));
  end
  // Guard nibble catches 10^DIGITS..10^(DIGITS+1)-1; anything wider is caught by the latched range check.
  assign sh  = {adj[SW-2:0], shift_q, 1'b0};
  assign sat = big_q | adj[SW-1] | (|sh[SW+WIDTH-1 -: BCD_W]);
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    scr_d    = scr_q;
    bcnt_d   = bcnt_q;
    big_d    = big_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (bus.load_i) begin
        shift_d = bus.value_i;
        scr_d   = '0;
        bcnt_d  = CW'(WIDTH);
        big_d   = {{(64-WIDTH){1'b0}}, bus.value_i} > LIMIT;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, shift_d} = sh;
        bcnt_d = bcnt_q - CW'(1);
        if (bcnt_q == CW'(1)) begin
          digits_d = sat ? {DIGITS{4'h9}} : sh[WIDTH +: DW];
          ovf_d    = sat;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d = cnt_q == RW'(REFRESH_DIV - 1) ? '0 : cnt_q + RW'(1);
  assign idx_d = cnt_q != RW'(REFRESH_DIV - 1) ? idx_q : idx_q == IW'(DIGITS - 1) ? '0 : idx_q + IW'(1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      scr_q    <= '0;
      bcnt_q   <= '0;
      big_q    <= 1'b0;
      digits_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      scr_q    <= scr_d;
      bcnt_q   <= bcnt_d;
      big_q    <= big_d;
      digits_q <= digits_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
    end
  end
  assign bus.busy_o   = state_q != IDLE;
  assign bus.done_o   = state_q == DONE;
  assign bus.ovf_o    = ovf_q;
  assign bus.digits_o = digits_q;
  assign digit_o      = digits_q[BCD_W*idx_q +: BCD_W];
`ifdef SCORE_DISP_LZB_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) if (|digits_q[BCD_W*i +: BCD_W]) msd = IW'(i);
  end
  assign an_o = idx_q > msd ? '1 : ~(DIGITS'(1) << idx_q);
`else
  assign an_o = ~(DIGITS'(1) << idx_q);
`endif
endmodule

// File: tb/tb_score_disp_ctrl.sv
// tb_score_disp_ctrl: directed conversions with a done-driven scoreboard, plus reset and scan checks.
module tb_score_disp_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] an, dig;
  int tests = 0, fails = 0;
  logic [16:0] exp_q[$];
  score_disp_ctrl_if #(.WIDTH(12), .DIGITS(4)) bus();
  score_disp_ctrl #(.WIDTH(12), .DIGITS(4), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .an_o(an), .digit_o(dig)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && bus.done_o) begin
      if (exp_q.size() == 0) chk("spurious done", 32'(bus.done_o), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("digits", 32'(bus.digits_o), 32'(e[15:0]));
        chk("ovf", 32'(bus.ovf_o), 32'(e[16]));
      end
    end
  end
  task automatic drive_load(input logic [11:0] v, input logic [15:0] e);
    bus.value_i = v;
    bus.load_i  = 1'b1;
    exp_q.push_back({1'b0, e});
    @(posedge clk);
    #1 bus.load_i = 1'b0;
  endtask
  task automatic wait_conv(input int ignore_at, input logic [11:0] iv);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bus.load_i = 1'b0;
      if (k == ignore_at) begin
        bus.value_i = iv;
        bus.load_i  = 1'b1;
      end
      chk("busy", 32'(bus.busy_o), 32'd1);
      chk("done timing", 32'(bus.done_o), 32'(k == 13));
    end
  endtask
  task automatic chk_reset_vals();
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst ovf", 32'(bus.ovf_o), 32'd0);
    chk("rst digits", 32'(bus.digits_o), 32'h0000);
    chk("rst an", 32'(an), 32'b1110);
    chk("rst digit", 32'(dig), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] exp_an[4];
    logic [3:0] exp_dig[4];
    logic [3:0] prev;
    logic       found;
`ifdef SCORE_DISP_LZB_EN
    exp_an = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
`else
    exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
`endif
    exp_dig = '{4'd2, 4'd4, 4'd0, 4'd0};
    bus.value_i = '0;
    bus.load_i  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals();
    // single conversion with exact busy/done timing
    drive_load(12'd1234, 16'h1234);
    wait_conv(0, '0);
    @(negedge clk);
    chk("idle busy", 32'(bus.busy_o), 32'd0);
    // back-to-back: each new load on the cycle after done
    drive_load(12'd4095, 16'h4095);
    wait_conv(0, '0);
    @(negedge clk);
    drive_load(12'd0, 16'h0000);
    wait_conv(0, '0);
    @(negedge clk);
    drive_load(12'd9, 16'h0009);
    wait_conv(0, '0);
    @(negedge clk);
    drive_load(12'd1000, 16'h1000);
    wait_conv(0, '0);
    @(negedge clk);
    // load during busy is dropped
    drive_load(12'd1234, 16'h1234);
    wait_conv(5, 12'd777);
    repeat (20) @(negedge clk);
    chk("after ignored load busy", 32'(bus.busy_o), 32'd0);
    chk("after ignored load digits", 32'(bus.digits_o), 32'h1234);
    // async reset mid-conversion
    drive_load(12'd999, 16'h0999);
    for (int k = 1; k <= 6; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post-reset digits", 32'(bus.digits_o), 32'h0000);
    chk("post-reset busy", 32'(bus.busy_o), 32'd0);
    // scan pattern for 0042
    drive_load(12'd42, 16'h0042);
    wait_conv(0, '0);
    prev  = an;
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = an;
    end
    chk("scan sync", 32'(found), 32'd1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clk);
        chk("scan an", 32'(an), 32'(exp_an[i/4]));
        chk("scan digit", 32'(dig), 32'(exp_dig[i/4]));
      end
    end
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
